// File: rtl/ramcic_interp_pkg.sv
// Shared definitions for the RAM-based CIC interpolator: FSM encodings,
// state-RAM geometry and the bit-width helper used to size the datapath.
package ramcic_interp_pkg;

    localparam int RAM_DEPTH = 64;
    localparam int RAM_AW    = 6;

    typedef enum logic [3:0] {
        ST_CLEAR      = 4'd0,
        ST_IDLE       = 4'd1,
        ST_COMB_START = 4'd2,
        ST_COMB_S2    = 4'd3,
        ST_COMB       = 4'd4,
        ST_COMB_END   = 4'd5,
        ST_INT_START  = 4'd6,
        ST_INT_S2     = 4'd7,
        ST_INT        = 4'd8,
        ST_INT_END    = 4'd9
    } state_t;

    // Number of bits needed to represent value (1 -> 1, 3 -> 2, 4 -> 3).
    function automatic int clogb2(input int value);
        int bits;
        bits = 0;
        for (int i = 0; i < 31; i++) begin
            bits = ((value >> i) != 0) ? i + 1 : bits;
        end
        return bits;
    endfunction

endpackage

// File: rtl/ramcic_interp_if.sv
// Sample-stream interface between the TX baseband source, the CIC
// interpolator and the high-rate consumer.
interface ramcic_interp_if #(
    parameter int IN_WIDTH  = 24,
    parameter int OUT_WIDTH = 16
);
    logic                        in_strobe;
    logic signed [IN_WIDTH-1:0]  in_data;
    logic                        out_req;
    logic                        out_strobe;
    logic signed [OUT_WIDTH-1:0] out_data;
    logic                        ready;
    logic                        underrun;

    modport master (
        output in_strobe, in_data, out_req,
        input  out_strobe, out_data, ready, underrun
    );

    modport slave (
        input  in_strobe, in_data, out_req,
        output out_strobe, out_data, ready, underrun
    );
endinterface

// File: rtl/ramcic_interp_cic_ram.sv
// Comb-delay / integrator state store: one synchronous read port and one
// synchronous write port, no reset so it maps onto block RAM.
module cic_ram
    import ramcic_interp_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [RAM_AW-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [RAM_AW-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);
    logic [WIDTH-1:0] mem_r [RAM_DEPTH];

    // Registered read and write of the state array.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        rdata <= mem_r[raddr];
    end
endmodule

// File: rtl/ramcic_interp.sv
// N-stage CIC interpolator that time-shares one adder over all stages; comb
// delays live at RAM {1,k}, integrator accumulators at {0,k}.
module ramcic_interp
    import ramcic_interp_pkg::*;
#(
    parameter int STAGES    = 10,
    parameter int INTERP    = 4,
    parameter int IN_WIDTH  = 24,
    parameter int OUT_WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    ramcic_interp_if.slave  bus
);
    localparam int PHASE_W   = clogb2(INTERP - 1);
    localparam int ACC_WIDTH = IN_WIDTH + STAGES * PHASE_W;
    localparam logic [4:0] LAST_STAGE = 5'(STAGES - 1);

    state_t                 state_r, state_s;
    logic [5:0]             clr_r;
    logic [4:0]             stage_r;
    logic [PHASE_W-1:0]     phase_r;
    logic                   comb_pend_r, int_pend_r, fresh_r, accept_s;
    logic [IN_WIDTH-1:0]    in_hold_r;
    logic [ACC_WIDTH-1:0]   work_r, comb_hold_r, rdata_s, wdata_s, sext_s;
    logic [RAM_AW-1:0]      raddr_s, waddr_s;
    logic                   we_s, ram_we_s;
    logic                   out_strobe_r, ready_r, underrun_r;
    logic [OUT_WIDTH-1:0]   out_data_r, rounded_s;

    cic_ram #(.WIDTH(ACC_WIDTH)) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .waddr (waddr_s),
        .wdata (wdata_s),
        .raddr (raddr_s),
        .rdata (rdata_s)
    );

    assign ram_we_s = we_s & rst_n;
    assign accept_s = (state_r != ST_CLEAR);
    assign sext_s   = {{(ACC_WIDTH - IN_WIDTH){in_hold_r[IN_WIDTH-1]}}, in_hold_r};

    generate
        if (ACC_WIDTH > OUT_WIDTH) begin : g_round
            logic [OUT_WIDTH:0] sum_s;
            // Round half up on the bit below the kept field; clamp to +max on overflow.
            always_comb begin
                sum_s = {work_r[ACC_WIDTH-1], work_r[ACC_WIDTH-1 -: OUT_WIDTH]}
                      + {{OUT_WIDTH{1'b0}}, work_r[ACC_WIDTH-OUT_WIDTH-1]};
                if (sum_s[OUT_WIDTH] != sum_s[OUT_WIDTH-1]) begin
                    rounded_s = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
                end else begin
                    rounded_s = sum_s[OUT_WIDTH-1:0];
                end
            end
        end else begin : g_no_round
            assign rounded_s = work_r[OUT_WIDTH-1:0];
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_CLEAR;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; integrator requests take priority over comb work.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_CLEAR:      state_s = (clr_r == 6'd63) ? ST_IDLE : ST_CLEAR;
            ST_IDLE: begin
                if (int_pend_r) begin
                    state_s = ST_INT_START;
                end else if (comb_pend_r) begin
                    state_s = ST_COMB_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_COMB_START: state_s = ST_COMB_S2;
            ST_COMB_S2:    state_s = ST_COMB;
            ST_COMB:       state_s = (stage_r == LAST_STAGE) ? ST_COMB_END : ST_COMB;
            ST_COMB_END:   state_s = ST_IDLE;
            ST_INT_START:  state_s = ST_INT_S2;
            ST_INT_S2:     state_s = ST_INT;
            ST_INT:        state_s = (stage_r == LAST_STAGE) ? ST_INT_END : ST_INT;
            ST_INT_END:    state_s = ST_IDLE;
            default:       state_s = ST_IDLE;
        endcase
    end

    // RAM port control: reads run one stage ahead of the write-back.
    always_comb begin
        we_s    = 1'b0;
        waddr_s = 6'd0;
        raddr_s = 6'd0;
        wdata_s = {ACC_WIDTH{1'b0}};
        case (state_r)
            ST_CLEAR: begin
                we_s    = 1'b1;
                waddr_s = clr_r;
            end
            ST_COMB_S2: raddr_s = {1'b1, 5'd0};
            ST_COMB: begin
                raddr_s = {1'b1, stage_r + 5'd1};
                we_s    = 1'b1;
                waddr_s = {1'b1, stage_r};
                wdata_s = work_r;
            end
            ST_INT_S2: raddr_s = {1'b0, 5'd0};
            ST_INT: begin
                raddr_s = {1'b0, stage_r + 5'd1};
                we_s    = 1'b1;
                waddr_s = {1'b0, stage_r};
                wdata_s = work_r + rdata_s;
            end
            default: we_s = 1'b0;
        endcase
    end

    // Pending-work latches; a new strobe wins over the consume in the same clock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            comb_pend_r <= 1'b0;
            int_pend_r  <= 1'b0;
            in_hold_r   <= {IN_WIDTH{1'b0}};
        end else begin
            if (bus.in_strobe && accept_s) begin
                comb_pend_r <= 1'b1;
                in_hold_r   <= bus.in_data;
            end else if (state_r == ST_COMB_START) begin
                comb_pend_r <= 1'b0;
            end
            if (bus.out_req && accept_s) begin
                int_pend_r <= 1'b1;
            end else if (state_r == ST_INT_START) begin
                int_pend_r <= 1'b0;
            end
        end
    end

    // Datapath, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clr_r        <= 6'd0;
            stage_r      <= 5'd0;
            phase_r      <= {PHASE_W{1'b0}};
            fresh_r      <= 1'b0;
            work_r       <= {ACC_WIDTH{1'b0}};
            comb_hold_r  <= {ACC_WIDTH{1'b0}};
            out_strobe_r <= 1'b0;
            out_data_r   <= {OUT_WIDTH{1'b0}};
            ready_r      <= 1'b0;
            underrun_r   <= 1'b0;
        end else begin
            out_strobe_r <= 1'b0;
            case (state_r)
                ST_CLEAR: begin
                    clr_r   <= clr_r + 6'd1;
                    ready_r <= (clr_r == 6'd63);
                end
                ST_COMB_START: begin
                    work_r  <= sext_s;
                    stage_r <= 5'd0;
                end
                ST_COMB: begin
                    work_r  <= work_r - rdata_s;
                    stage_r <= stage_r + 5'd1;
                end
                ST_COMB_END: begin
                    comb_hold_r <= work_r;
                    fresh_r     <= 1'b1;
                end
                ST_INT_START: begin
                    stage_r <= 5'd0;
                    if (phase_r == {PHASE_W{1'b0}}) begin
                        work_r     <= fresh_r ? comb_hold_r : {ACC_WIDTH{1'b0}};
                        fresh_r    <= 1'b0;
                        underrun_r <= underrun_r | ~fresh_r;
                    end else begin
                        work_r <= {ACC_WIDTH{1'b0}};
                    end
                end
                ST_INT: begin
                    work_r  <= work_r + rdata_s;
                    stage_r <= stage_r + 5'd1;
                end
                ST_INT_END: begin
                    out_data_r   <= rounded_s;
                    out_strobe_r <= 1'b1;
                    phase_r      <= phase_r + {{(PHASE_W - 1){1'b0}}, 1'b1};
                end
                default: out_strobe_r <= 1'b0;
            endcase
        end
    end

    assign bus.out_strobe = out_strobe_r;
    assign bus.out_data   = out_data_r;
    assign bus.ready      = ready_r;
    assign bus.underrun   = underrun_r;
endmodule

// File: tb/tb_ramcic_interp.sv
// Directed bench: two interpolators (22-bit and 16-bit outputs, STAGES=3,
// INTERP=4) share clock, reset and stimulus; each is checked against tables.
module tb_ramcic_interp;
    localparam int STAGES = 3;
    localparam int INTERP = 4;
    localparam int IN_W   = 16;
    localparam int OUT_A  = 22;
    localparam int OUT_B  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_n     = 1'b0;
    logic                   in_strobe = 1'b0;
    logic                   out_req   = 1'b0;
    logic signed [IN_W-1:0] in_data   = '0;

    ramcic_interp_if #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_A)) ifa ();
    ramcic_interp_if #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_B)) ifb ();

    assign ifa.in_strobe = in_strobe;
    assign ifa.in_data   = in_data;
    assign ifa.out_req   = out_req;
    assign ifb.in_strobe = in_strobe;
    assign ifb.in_data   = in_data;
    assign ifb.out_req   = out_req;

    ramcic_interp #(.STAGES(STAGES), .INTERP(INTERP), .IN_WIDTH(IN_W), .OUT_WIDTH(OUT_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa));
    ramcic_interp #(.STAGES(STAGES), .INTERP(INTERP), .IN_WIDTH(IN_W), .OUT_WIDTH(OUT_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb));

    int errors = 0;
    int checks = 0;

    logic signed [OUT_A-1:0] cap_a [16];
    logic signed [OUT_B-1:0] cap_b [16];
    bit                      got   [16];

    int h   [10] = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1};
    int p32 [16] = '{1, 2, 3, 5, 6, 6, 5, 3, 2, 1, 0, 0, 0, 0, 0, 0};
    int n32 [16] = '{0, -1, -3, -5, -6, -6, -5, -3, -1, 0, 0, 0, 0, 0, 0, 0};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; in_strobe = 1'b0; out_req = 1'b0; in_data = '0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 64; i++) tick();
        checks++;
        if (ifa.ready !== 1'b1 || ifb.ready !== 1'b1) begin
            errors++;
            $display("FAIL wait_ready: ready=%b/%b required 1/1", ifa.ready, ifb.ready);
        end
    endtask

    task automatic sample(input int v);
        in_data   = v[IN_W-1:0];
        in_strobe = 1'b1;
        tick();
        in_strobe = 1'b0;
        repeat (10) tick();
    endtask

    task automatic request(input int idx);
        out_req = 1'b1;
        tick();
        out_req  = 1'b0;
        got[idx] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ifa.out_strobe === 1'b1 && !got[idx]) begin
                got[idx]   = 1'b1;
                cap_a[idx] = ifa.out_data;
                cap_b[idx] = ifb.out_data;
            end
        end
        checks++;
        if (!got[idx]) begin
            errors++;
            $display("FAIL request_timeout[%0d]: out_strobe seen=0 required 1", idx);
        end
    endtask

    task automatic run_blocks(input int first, input int rest);
        for (int j = 0; j < 4; j++) begin
            sample((j == 0) ? first : rest);
            for (int p = 0; p < 4; p++) request(4 * j + p);
        end
    endtask

    task automatic test_reset();
        logic exp_ready;
        apply_reset();
        for (int i = 1; i <= 70; i++) begin
            tick();
            exp_ready = (i >= 64);
            checks++;
            if (ifa.ready !== exp_ready || ifb.ready !== exp_ready) begin
                errors++;
                $display("FAIL reset_ready[clk %0d]: ready=%b/%b required %b", i, ifa.ready, ifb.ready, exp_ready);
            end
            checks++;
            if (ifa.out_strobe !== 1'b0 || ifa.out_data !== '0 || ifb.out_data !== '0 || ifa.underrun !== 1'b0) begin
                errors++;
                $display("FAIL reset_quiet[clk %0d]: strobe=%b data=%0d/%0d underrun=%b required 0", i,
                         ifa.out_strobe, ifa.out_data, ifb.out_data, ifa.underrun);
            end
        end
    endtask

    task automatic test_underrun();
        apply_reset();
        wait_ready();
        request(0);
        checks++;
        if (ifa.underrun !== 1'b1 || ifb.underrun !== 1'b1) begin
            errors++;
            $display("FAIL underrun_flag: underrun=%b/%b required 1/1", ifa.underrun, ifb.underrun);
        end
        checks++;
        if (cap_a[0] !== '0 || cap_b[0] !== '0) begin
            errors++;
            $display("FAIL underrun_data: out_data=%0d/%0d required 0", cap_a[0], cap_b[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_s;
        apply_reset();
        wait_ready();
        in_data   = 16'sd5;
        in_strobe = 1'b1;
        out_req   = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            in_strobe = 1'b0;
            out_req   = 1'b0;
            exp_s     = (i == STAGES + 5);
            checks++;
            if (ifa.out_strobe !== exp_s) begin
                errors++;
                $display("FAIL same_clk_latency[clk %0d]: out_strobe=%b required %b", i, ifa.out_strobe, exp_s);
            end
        end
        repeat (10) tick();
        for (int p = 1; p <= 4; p++) request(p);
        checks++;
        if (cap_a[4] !== 22'sd5) begin
            errors++;
            $display("FAIL same_clk_comb_after: out_data=%0d required 5", cap_a[4]);
        end
    endtask

    task automatic check_impulse(input int amp, input string tag);
        logic signed [OUT_A-1:0] ea;
        int e;
        for (int n = 0; n < 16; n++) begin
            e  = (n < 10) ? amp * h[n] : 0;
            ea = e[OUT_A-1:0];
            checks++;
            if (cap_a[n] !== ea) begin
                errors++;
                $display("FAIL %s[%0d]: out_data=%0d required %0d", tag, n, cap_a[n], ea);
            end
        end
    endtask

    task automatic test_impulse();
        apply_reset();
        wait_ready();
        run_blocks(1, 0);
        check_impulse(1, "impulse22");
    endtask

    task automatic test_rounding();
        logic signed [OUT_B-1:0] eb;
        apply_reset();
        wait_ready();
        run_blocks(32, 0);
        check_impulse(32, "impulse22_x32");
        for (int n = 0; n < 16; n++) begin
            eb = p32[n][OUT_B-1:0];
            checks++;
            if (cap_b[n] !== eb) begin
                errors++;
                $display("FAIL round_pos[%0d]: out_data=%0d required %0d", n, cap_b[n], eb);
            end
        end
        run_blocks(-32, 0);
        for (int n = 0; n < 16; n++) begin
            eb = n32[n][OUT_B-1:0];
            checks++;
            if (cap_b[n] !== eb) begin
                errors++;
                $display("FAIL round_neg[%0d]: out_data=%0d required %0d", n, cap_b[n], eb);
            end
        end
    endtask

    task automatic test_dc();
        apply_reset();
        wait_ready();
        run_blocks(4000, 4000);
        for (int n = 10; n < 16; n++) begin
            checks++;
            if (cap_a[n] !== 22'sd64000 || cap_b[n] !== 16'sd1000) begin
                errors++;
                $display("FAIL dc_pos[%0d]: out_data=%0d/%0d required 64000/1000", n, cap_a[n], cap_b[n]);
            end
        end
        run_blocks(-4000, -4000);
        for (int n = 10; n < 16; n++) begin
            checks++;
            if (cap_a[n] !== -22'sd64000 || cap_b[n] !== -16'sd1000) begin
                errors++;
                $display("FAIL dc_neg[%0d]: out_data=%0d/%0d required -64000/-1000", n, cap_a[n], cap_b[n]);
            end
        end
    endtask

    task automatic test_reset_mid_comb();
        bit strobe_seen;
        apply_reset();
        wait_ready();
        sample(4000);
        for (int p = 0; p < 4; p++) request(p);
        in_data   = 16'sd1234;
        in_strobe = 1'b1;
        tick();
        in_strobe = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        strobe_seen = 1'b0;
        for (int i = 1; i <= 70; i++) begin
            tick();
            if (ifa.out_strobe === 1'b1 || ifb.out_strobe === 1'b1) strobe_seen = 1'b1;
            if (i == 63) begin
                checks++;
                if (ifa.ready !== 1'b0) begin
                    errors++;
                    $display("FAIL mid_reset_ready_early: ready=%b required 0", ifa.ready);
                end
            end
        end
        checks++;
        if (strobe_seen) begin
            errors++;
            $display("FAIL mid_reset_strobe: out_strobe seen=1 required 0");
        end
        checks++;
        if (ifa.ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_ready: ready=%b required 1", ifa.ready);
        end
        run_blocks(1, 0);
        check_impulse(1, "impulse_after_reset");
    endtask

    initial begin
        test_reset();
        test_underrun();
        test_back_to_back();
        test_impulse();
        test_rounding();
        test_dc();
        test_reset_mid_comb();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
